// File: rtl/dcache_fsm_wb_nway.sv
`default_nettype none
// ============================================================================
// dcache_fsm_wb_nway : N-way write-back/write-allocate L1 D-cache control FSM
// Revision: 1.0
// ============================================================================
module dcache_fsm_wb_nway #(
    parameter int WAY = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     pipe_valid,
    input  logic                     pipe_opflag,
    input  logic                     pipe_flush,
    output logic                     pipe_ready,
    output logic                     pipe_stall,
    output logic                     ack_op,
    output logic                     rbuf_we,
    input  logic                     rbuf_type,
    input  logic                     rbuf_suc,
    input  logic [1:0]               rbuf_opcode,
    input  logic [$clog2(WAY)-1:0]   rbuf_way,
    input  logic [WAY-1:0]           hit,
    input  logic [WAY-1:0]           dirty,
    input  logic [$clog2(WAY)-1:0]   victim,
    output logic                     use_en,
    output logic [$clog2(WAY)-1:0]   use_way,
    output logic [WAY-1:0]           data_we,
    output logic [WAY-1:0]           tagv_we,
    output logic                     dirty_set,
    output logic [WAY-1:0]           tagv_inval,
    output logic [WAY-1:0]           tagv_init,
    output logic                     data_replace,
    output logic [$clog2(WAY)-1:0]   choose_way,
    output logic                     choose_return,
    output logic                     mem_req,
    output logic                     mem_wr,
    output logic                     mem_wb_sel,
    input  logic                     mem_addrOK,
    input  logic                     mem_dataOK
);

    localparam int WAY_W = $clog2(WAY);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        LOOKUP  = 4'd1,
        MISS_WB = 4'd2,
        MISS_RD = 4'd3,
        REFILL  = 4'd4,
        UNC_W   = 4'd5,
        OP      = 4'd6,
        OP_WB   = 4'd7,
        FLUSH   = 4'd8
    } state_t;

    state_t             state;
    state_t             next_state;
    state_t             adv_state;
    logic [WAY_W-1:0]   hw;
    logic               hit_any;
    logic [WAY_W-1:0]   sel_way;
    logic               sel_dirty;
    logic               op_skip;

    function automatic logic [WAY-1:0] onehot(input logic [WAY_W-1:0] w);
        onehot = {{(WAY-1){1'b0}}, 1'b1} << w;
    endfunction

    // Descending scan so the lowest hitting way wins on multiple hits.
    always_comb begin
        hw = '0;
        for (int i = WAY - 1; i >= 0; i--) begin
            if (hit[i]) hw = WAY_W'(i);
        end
    end

    assign hit_any   = |hit;
    assign sel_way   = (rbuf_opcode == 2'd2) ? hw : rbuf_way;
    assign sel_dirty = dirty[sel_way];
    assign op_skip   = (rbuf_opcode == 2'd2) && !hit_any;
    assign adv_state = pipe_valid ? (pipe_opflag ? OP : LOOKUP) : IDLE;

    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state    = state;
        pipe_ready    = 1'b0;
        ack_op        = 1'b0;
        use_en        = 1'b0;
        use_way       = '0;
        data_we       = '0;
        tagv_we       = '0;
        dirty_set     = 1'b0;
        tagv_inval    = '0;
        tagv_init     = '0;
        data_replace  = 1'b0;
        choose_way    = '0;
        choose_return = 1'b0;
        mem_req       = 1'b0;
        mem_wr        = 1'b0;
        mem_wb_sel    = 1'b0;
        case (state)
            IDLE: begin
                pipe_ready = 1'b1;
                next_state = adv_state;
            end
            LOOKUP: begin
                if (pipe_flush) begin
                    next_state = FLUSH;
                end else if (rbuf_suc) begin
                    // Uncached access evicts any stale cached copy on the way out.
                    mem_req = 1'b1;
                    mem_wr  = rbuf_type;
                    if (hit_any) tagv_inval = onehot(hw);
                    if (!rbuf_type)      next_state = MISS_RD;
                    else if (mem_addrOK) begin
                        pipe_ready = 1'b1;
                        next_state = adv_state;
                    end else             next_state = UNC_W;
                end else if (hit_any) begin
                    pipe_ready = 1'b1;
                    use_en     = 1'b1;
                    use_way    = hw;
                    choose_way = hw;
                    if (rbuf_type) begin
                        data_we   = onehot(hw);
                        tagv_we   = onehot(hw);
                        dirty_set = 1'b1;
                    end
                    next_state = adv_state;
                end else begin
                    next_state = dirty[victim] ? MISS_WB : MISS_RD;
                end
            end
            MISS_WB: begin
                mem_req    = 1'b1;
                mem_wr     = 1'b1;
                mem_wb_sel = 1'b1;
                if (mem_addrOK) next_state = MISS_RD;
            end
            MISS_RD: begin
                mem_req = 1'b1;
                if (mem_dataOK) begin
                    choose_return = 1'b1;
                    next_state    = REFILL;
                end
            end
            REFILL: begin
                pipe_ready   = 1'b1;
                data_replace = 1'b1;
                if (!rbuf_suc) begin
                    data_we   = onehot(victim);
                    tagv_we   = onehot(victim);
                    use_en    = 1'b1;
                    use_way   = victim;
                    dirty_set = rbuf_type;
                end
                next_state = adv_state;
            end
            UNC_W: begin
                mem_req = 1'b1;
                mem_wr  = 1'b1;
                if (mem_addrOK) begin
                    pipe_ready = 1'b1;
                    next_state = adv_state;
                end
            end
            OP: begin
                if (pipe_flush) begin
                    next_state = FLUSH;
                end else if (rbuf_opcode == 2'd0) begin
                    tagv_init  = onehot(rbuf_way);
                    pipe_ready = 1'b1;
                    ack_op     = 1'b1;
                    next_state = adv_state;
                end else if (rbuf_opcode == 2'd3 || op_skip) begin
                    pipe_ready = 1'b1;
                    ack_op     = 1'b1;
                    next_state = adv_state;
                end else if (sel_dirty) begin
                    next_state = OP_WB;
                end else begin
                    tagv_inval = onehot(sel_way);
                    pipe_ready = 1'b1;
                    ack_op     = 1'b1;
                    next_state = adv_state;
                end
            end
            OP_WB: begin
                mem_req    = 1'b1;
                mem_wr     = 1'b1;
                mem_wb_sel = 1'b1;
                if (mem_addrOK) begin
                    tagv_inval = onehot(sel_way);
                    pipe_ready = 1'b1;
                    ack_op     = 1'b1;
                    next_state = adv_state;
                end
            end
            FLUSH: begin
                pipe_ready = 1'b1;
                next_state = pipe_flush ? FLUSH : adv_state;
            end
            default: next_state = IDLE;
        endcase
    end

    assign rbuf_we    = pipe_ready;
    assign pipe_stall = ~pipe_ready;

endmodule
`default_nettype wire
